change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: buffers change-coin denomination codes from the vending
// FSM and drives the coin hopper one eject at a time. It enforces a minimum
// gap between ejects, a hopper timeout that flushes the queue, and sticky
// overflow/error flags.
//
// Optional build macro: CHANGE_DISPENSER_TALLY_EN
//   defined   -> o_tally accumulates the value of each completed eject
//   undefined -> o_tally is tied to 0; no value table or adder is built
//
// FSM states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | nothing in flight, o_eject_code = 0; pops the FIFO head
//   ST_EJECT | o_eject high, waiting for i_eject_done or the timeout
//   ST_GAP   | o_eject low for GAP_CYCLES; may chain straight into the
//            | next eject so the low time is exactly GAP_CYCLES
//   ST_ERROR | hopper timed out; FIFO flushed and pushes dropped until
//            | i_err_clr
module change_dispenser #(
    parameter int FIFO_DEPTH    = 4,
    parameter int EJECT_TIMEOUT = 255,
    parameter int GAP_CYCLES    = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_change_code,
    input  logic        i_change_valid,
    input  logic        i_no_change,
    output logic [3:0]  o_eject_code,
    output logic        o_eject,
    input  logic        i_eject_done,
    output logic        o_busy,
    output logic        o_short,
    output logic        o_overflow,
    output logic        o_error,
    input  logic        i_err_clr,
    input  logic        i_tally_clr,
    output logic [20:0] o_tally
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = AW + 1;
    localparam int TMAX = (EJECT_TIMEOUT > GAP_CYCLES) ? EJECT_TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // Timer loads are N-1 because the terminal count (0) is itself a cycle.
    localparam logic [TW-1:0] EJECT_LOAD = TW'(EJECT_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EJECT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          eject_q, eject_d;
    logic [3:0]    code_q, code_d;
    logic          short_q, short_d;
    logic          overflow_q, overflow_d;
    logic          error_q, error_d;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [3:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic [3:0]    fifo_head;
    logic          start_eject;
    logic          pop;
    logic          flush;
    logic          done_ok;
    logic          error_set;
    logic          push_req;
    logic          push_blocked;
    logic          push;
    logic          overflow_evt;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_head  = mem_q[rd_ptr_q];

    // Eject sequencer: state, shared down-counter and hopper-facing outputs.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        eject_d     = eject_q;
        code_d      = code_q;
        start_eject = 1'b0;
        flush       = 1'b0;
        done_ok     = 1'b0;
        error_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                eject_d = 1'b0;
                code_d  = '0;
                if (!fifo_empty) begin
                    start_eject = 1'b1;
                end
            end
            ST_EJECT: begin
                if (i_eject_done) begin
                    state_d = ST_GAP;
                    eject_d = 1'b0;
                    code_d  = '0;
                    timer_d = GAP_LOAD;
                    done_ok = 1'b1;
                end else if (timer_q == '0) begin
                    state_d   = ST_ERROR;
                    eject_d   = 1'b0;
                    code_d    = '0;
                    flush     = 1'b1;
                    error_set = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    if (!fifo_empty) begin
                        start_eject = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_ERROR: begin
                eject_d = 1'b0;
                code_d  = '0;
                if (i_err_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                eject_d = 1'b0;
                code_d  = '0;
            end
        endcase

        if (start_eject) begin
            state_d = ST_EJECT;
            eject_d = 1'b1;
            code_d  = fifo_head;
            timer_d = EJECT_LOAD;
        end
    end

    assign pop = start_eject;

    // Input acceptance: pushes, no-change pulse and overflow detection.
    // The edge that enters ERROR also drops input, since it flushes the FIFO.
    always_comb begin
        push_req     = i_change_valid && !i_no_change && (i_change_code != 4'd0);
        push_blocked = (state_q == ST_ERROR) || flush;
        push         = push_req && !push_blocked && (!fifo_full || pop);
        overflow_evt = push_req && !push_blocked && fifo_full && !pop;
        short_d      = i_change_valid && i_no_change && !push_blocked;
        // A new event wins over a simultaneous clear so it is never lost.
        overflow_d   = (overflow_q && !i_err_clr) || overflow_evt;
        error_d      = (error_q && !i_err_clr) || error_set;
    end

    // FIFO pointer, occupancy and storage update.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = i_change_code;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control and flag registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            eject_q    <= 1'b0;
            code_q     <= '0;
            short_q    <= 1'b0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            eject_q    <= eject_d;
            code_q     <= code_d;
            short_q    <= short_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count_q so no reset is needed.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_eject      = eject_q;
    assign o_eject_code = code_q;
    assign o_short      = short_q;
    assign o_overflow   = overflow_q;
    assign o_error      = error_q;
    // ERROR is excluded: after a timeout the dispenser is halted, not working.
    assign o_busy       = !fifo_empty || (state_q == ST_EJECT) || (state_q == ST_GAP);

`ifdef CHANGE_DISPENSER_TALLY_EN
    logic [20:0] tally_q, tally_d;

    // Coin value in 0.01 units; codes follow the 5-2-1 series from 500 down.
    function automatic logic [15:0] coin_value(input logic [3:0] code);
        case (code)
            4'd1:    coin_value = 16'd50000;
            4'd2:    coin_value = 16'd20000;
            4'd3:    coin_value = 16'd10000;
            4'd4:    coin_value = 16'd5000;
            4'd5:    coin_value = 16'd2000;
            4'd6:    coin_value = 16'd1000;
            4'd7:    coin_value = 16'd500;
            4'd8:    coin_value = 16'd200;
            4'd9:    coin_value = 16'd100;
            4'd10:   coin_value = 16'd50;
            4'd11:   coin_value = 16'd20;
            4'd12:   coin_value = 16'd10;
            4'd13:   coin_value = 16'd5;
            4'd14:   coin_value = 16'd2;
            4'd15:   coin_value = 16'd1;
            default: coin_value = 16'd0;
        endcase
    endfunction

    // Tally accumulates completed ejects; clear wins over add, wraps at 2^21.
    always_comb begin
        tally_d = tally_q;
        if (i_tally_clr) begin
            tally_d = '0;
        end else if (done_ok) begin
            tally_d = tally_q + 21'(coin_value(code_q));
        end
    end

    // Tally register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tally_q <= '0;
        end else begin
            tally_q <= tally_d;
        end
    end

    assign o_tally = tally_q;
`else
    logic unused_tally;
    assign unused_tally = i_tally_clr | done_ok;
    assign o_tally      = '0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser (default parameters).
module tb_change_dispenser;

    localparam int GAP     = 3;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  code;
    logic        valid;
    logic        no_change;
    logic [3:0]  eject_code;
    logic        eject;
    logic        eject_done;
    logic        busy;
    logic        short_p;
    logic        overflow;
    logic        error;
    logic        err_clr;
    logic        tally_clr;
    logic [20:0] tally;

    logic        hop_done   = 1'b0;
    logic        force_done = 1'b0;
    int          hopper_delay = 2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_q[$];
    int          ej_cnt = 0;
    logic        ej_prev = 1'b0;
    logic [3:0]  cur_code = '0;
    int          rises = 0;
    int          t_fall;
    int          t_rise2;
    int          hi;
    int          r0;

    assign eject_done = hop_done | force_done;

    always #5 clk = ~clk;

    change_dispenser dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_change_code  (code),
        .i_change_valid (valid),
        .i_no_change    (no_change),
        .o_eject_code   (eject_code),
        .o_eject        (eject),
        .i_eject_done   (eject_done),
        .o_busy         (busy),
        .o_short        (short_p),
        .o_overflow     (overflow),
        .o_error        (error),
        .i_err_clr      (err_clr),
        .i_tally_clr    (tally_clr),
        .o_tally        (tally)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

`ifdef CHANGE_DISPENSER_TALLY_EN
    function automatic int coin_val(input int c);
        int vals[16] = '{0, 50000, 20000, 10000, 5000, 2000, 1000, 500,
                         200, 100, 50, 20, 10, 5, 2, 1};
        return vals[c];
    endfunction
`endif

    // Hopper model and scoreboard: compare each new eject against the queue.
    always @(negedge clk) begin
        if (eject && !ej_prev) begin
            rises++;
            ej_cnt   = 0;
            cur_code = eject_code;
            if (exp_q.size() == 0) check("eject_unexpected", 1, 0);
            else check("eject_code", eject_code, exp_q.pop_front());
        end else if (eject) begin
            ej_cnt++;
            check("code_stable", eject_code, cur_code);
        end
        hop_done = eject && (hopper_delay >= 0) && (ej_cnt == hopper_delay);
        ej_prev  = eject;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; code = '0; valid = 1'b0; no_change = 1'b0;
        err_clr = 1'b0; tally_clr = 1'b0;
        repeat (3) tick();
        check("rst_eject", eject, 0);
        check("rst_code", eject_code, 0);
        check("rst_busy", busy, 0);
        check("rst_short", short_p, 0);
        check("rst_overflow", overflow, 0);
        check("rst_error", error, 0);
        check("rst_tally", tally, 0);
        rst = 1'b0;
        tick();

        // Two codes back-to-back, hopper acks after 2 cycles.
        hopper_delay = 2;
        code = 4'd3; valid = 1'b1; exp_q.push_back(3);
        tick();
        check("lat_push_edge", eject, 0);
        check("busy_after_push", busy, 1);
        code = 4'd7; exp_q.push_back(7);
        tick();
        valid = 1'b0; code = '0;
        check("lat_next_edge", eject, 1);
        check("first_code", eject_code, 3);
        t_fall = -1; t_rise2 = -1;
        for (int c = 1; c <= 40 && t_rise2 < 0; c++) begin
            tick();
            if (!eject && t_fall < 0) t_fall = c;
            else if (eject && t_fall >= 0) t_rise2 = c;
        end
        check("eject_high_len", t_fall, 3);
        check("gap_len", t_rise2 - t_fall, GAP);
        wait_idle(100);
        check("idle_code_zero", eject_code, 0);
`ifdef CHANGE_DISPENSER_TALLY_EN
        check("tally_sum", tally, coin_val(3) + coin_val(7));
`else
        check("tally_off", tally, 0);
`endif
        tally_clr = 1'b1; tick(); tally_clr = 1'b0;
        check("tally_clr", tally, 0);

        // Stalled hopper: fill FIFO, overflow, then timeout.
        hopper_delay = -1;
        foreach (exp_q[i]) exp_q.delete(i);
        for (int i = 0; i < 5; i++) begin
            code = 4'(i + 1); valid = 1'b1; exp_q.push_back(i + 1);
            tick();
        end
        check("no_overflow_at_5", overflow, 0);
        code = 4'd9;
        tick();
        valid = 1'b0; code = '0;
        check("overflow_at_6", overflow, 1);
        hi = 5;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (eject) hi++;
            else break;
        end
        check("timeout_len", hi, TIMEOUT);
        check("timeout_error", error, 1);
        check("timeout_eject", eject, 0);
        check("timeout_busy", busy, 0);
        check("timeout_ovf_kept", overflow, 1);
        exp_q.delete();
        code = 4'd5; valid = 1'b1;
        tick();
        valid = 1'b0; code = '0;
        check("err_push_dropped", busy, 0);
        check("err_push_no_ovf_change", overflow, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("errclr_error", error, 0);
        check("errclr_overflow", overflow, 0);
        repeat (5) tick();
        check("errclr_no_eject", eject, 0);
        check("errclr_busy", busy, 0);

        // No-change indication and code-0 drop.
        code = 4'd4; valid = 1'b1; no_change = 1'b1;
        tick();
        valid = 1'b0; no_change = 1'b0; code = '0;
        check("short_pulse", short_p, 1);
        tick();
        check("short_one_cycle", short_p, 0);
        check("short_no_eject", eject, 0);
        check("short_busy", busy, 0);
        code = 4'd0; valid = 1'b1;
        tick();
        valid = 1'b0;
        check("code0_dropped", busy, 0);
        tick();
        check("code0_no_eject", eject, 0);

        // Reset in the middle of an eject with two entries queued.
        hopper_delay = -1;
        for (int i = 0; i < 3; i++) begin
            code = 4'(8 + i); valid = 1'b1; exp_q.push_back(8 + i);
            tick();
        end
        valid = 1'b0; code = '0;
        check("pre_rst_eject", eject, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_eject", eject, 0);
        check("midrst_busy", busy, 0);
        check("midrst_code", eject_code, 0);
        exp_q.delete();
        r0 = rises;
        repeat (20) tick();
        check("midrst_no_more_ejects", rises - r0, 0);

        // Recovery after reset.
        hopper_delay = 2;
        code = 4'd15; valid = 1'b1; exp_q.push_back(15);
        tick();
        valid = 1'b0; code = '0;
        wait_idle(100);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
